// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the fifo_uart_tx drain stage: FSM state encoding and
// a constant clog2 used to size the bit timer and bit counter.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Counters need at least one bit even when the range collapses to a single value.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// serial bit. clr_i restarts the count so every state begins on a fresh bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic bit_end_o
);
    import fifo_uart_tx_pkg::*;

    localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from fifo_sync and serialises them as UART frames (start, LSB-first
// data, stop). Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before stop.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             fifo_rd_en_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             frame_done_o
);
    import fifo_uart_tx_pkg::*;

    localparam int               BIT_W    = cnt_width(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [BIT_W-1:0] bit_cnt_d;
    logic             tx_q;
    logic             tx_d;
    logic             rd_en_q;
    logic             rd_en_d;
    logic             bit_end;
    logic             timer_clr;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    assign timer_clr = (state_d != state_q);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (timer_clr),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_i && !fifo_empty_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Read data is valid the cycle after the pop.
                shift_d  = fifo_rdata_i;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^fifo_rdata_i;
`endif
                state_d  = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from next-state values so they line up with state_q.
        rd_en_d = (state_d == ST_FETCH);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx_o         = tx_q;
    assign fifo_rd_en_o = rd_en_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = (state_q == ST_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a behavioural fifo_sync upstream; a UART receiver
// monitor checks each frame against a scoreboard filled when bytes are written.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    localparam int WIDTH = 8;
    localparam int CPB   = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = WIDTH + 3;
`else
    localparam int NBITS = WIDTH + 2;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata = '0;
    logic             fifo_rd_en;
    logic             tx;
    logic             busy;
    logic             frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .fifo_empty_i(fifo_empty),
        .fifo_rdata_i(fifo_rdata),
        .fifo_rd_en_o(fifo_rd_en),
        .tx_o        (tx),
        .busy_o      (busy),
        .frame_done_o(frame_done)
    );

    // Upstream fifo_sync model, DEPTH 16
    logic             wr_en   = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] fifo_mem[$];
    int fifo_cnt     = 0;
    int pop_cnt      = 0;
    int rd_error_cnt = 0;

    assign fifo_empty = (fifo_cnt == 0);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_mem.size() == 0) begin
                rd_error_cnt <= rd_error_cnt + 1;
            end else begin
                fifo_rdata <= fifo_mem.pop_front();
                pop_cnt    <= pop_cnt + 1;
            end
        end
        if (wr_en && fifo_mem.size() < 16) fifo_mem.push_back(wr_data);
        fifo_cnt <= fifo_mem.size();
    end

    // Scoreboard and counters
    logic [WIDTH-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Monitor: UART receiver sampling on the falling clock edge
    int  cyc = 0;
    int  mon_started = 0;
    int  mon_done = 0;
    int  mon_aborted = 0;
    int  stray_done = 0;
    bit  in_frame = 0;
    bit  cand_valid = 0;
    bit  b2b = 0;
    int  cand_cyc = 0;
    int  last_done_cyc = 0;
    int  idx = 0;
    int  done_cnt = 0;
    bit  done_last = 0;
    bit  busy_bad = 0;
    int  bi = 0;
    logic [FRAME_CYC-1:0] got_v;
    logic [FRAME_CYC-1:0] want_v;
    logic [WIDTH-1:0]     got_b;
    logic [WIDTH-1:0]     want_b;

    always @(negedge clk) begin : monitor
        cyc = cyc + 1;
        if (rst) begin
            if (in_frame) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                mon_aborted++;
                $display("frame %0d abandoned by reset at sample %0d", mon_started, idx);
            end
            in_frame   = 0;
            cand_valid = 0;
            b2b        = 0;
        end else begin
            if (!in_frame) begin
                if (tx == 1'b0) begin
                    in_frame  = 1;
                    idx       = 0;
                    done_cnt  = 0;
                    done_last = 0;
                    busy_bad  = 0;
                    got_v     = '0;
                    mon_started++;
                    check("start_latency", cand_valid ? 64'(cyc - cand_cyc) : 64'hFFFF, 64'd3);
                    if (b2b) check("b2b_gap", 64'(cyc - last_done_cyc), 64'd4);
                    cand_valid = 0;
                end else begin
                    if (frame_done) stray_done++;
                    if (!cand_valid && !busy && en && !fifo_empty) begin
                        cand_valid = 1;
                        cand_cyc   = cyc;
                    end
                end
            end
            if (in_frame) begin
                got_v[idx] = tx;
                if (frame_done) begin
                    done_cnt++;
                    if (idx == FRAME_CYC - 1) done_last = 1;
                end
                if (!busy) busy_bad = 1;
                if (idx == FRAME_CYC - 1) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got a frame, expected none queued");
                        want_b = '0;
                    end else begin
                        want_b = exp_q.pop_front();
                    end
                    for (int i = 0; i < FRAME_CYC; i++) begin
                        bi = i / CPB;
                        if (bi == 0)              want_v[i] = 1'b0;
                        else if (bi <= WIDTH)     want_v[i] = want_b[bi-1];
                        else if (bi == NBITS - 1) want_v[i] = 1'b1;
                        else                      want_v[i] = ^want_b;
                    end
                    for (int k = 0; k < WIDTH; k++) got_b[k] = got_v[(k+1)*CPB + CPB/2];
                    check("frame_data", 64'(got_b), 64'(want_b));
                    check("frame_wave", 64'(got_v), 64'(want_v));
                    check("frame_done_pulse", {62'd0, done_cnt == 1, done_last}, 64'd3);
                    check("busy_in_frame", 64'(busy_bad), 64'd0);
                    $display("frame %0d: sent %02h received %02h", mon_done, want_b, got_b);
                    mon_done++;
                    in_frame      = 0;
                    last_done_cyc = cyc;
                    b2b           = en && !fifo_empty;
                end else begin
                    idx++;
                end
            end
        end
    end

    // Stimulus helpers
    task automatic write_byte(input logic [WIDTH-1:0] b);
        @(posedge clk); #2;
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(posedge clk); #2;
        wr_en = 1'b0;
    endtask

    task automatic set_en(input logic v);
        @(posedge clk); #2;
        en = v;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        while (mon_done < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(name, 64'(mon_done), 64'(target));
    endtask

    task automatic wait_started(input int target, input int budget, input string name);
        while (mon_started < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(name, 64'(mon_started), 64'(target));
    endtask

    task automatic idle_window(input int n, output int bad);
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) bad++;
        end
    endtask

    logic [WIDTH-1:0] burst [16] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0,
                                     8'h3C, 8'hC3, 8'h7E, 8'h81, 8'h12, 8'h34, 8'hDE, 8'h07};

    initial begin : stimulus
        int bad;
        int s0;
        rst = 1'b1;
        en  = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        idle_window(20, bad);
        check("idle_empty_quiet", 64'(bad), 64'd0);
        check("idle_no_pop", 64'(pop_cnt), 64'd0);

        // Single byte
        write_byte(8'hA5);
        wait_done(1, 200, "single_done");
        check("single_pops", 64'(pop_cnt), 64'd1);

        // Burst of 16 with the FIFO full before enabling
        set_en(1'b0);
        foreach (burst[i]) write_byte(burst[i]);
        repeat (2) @(posedge clk);
        check("burst_full", 64'(fifo_cnt), 64'd16);
        set_en(1'b1);
        wait_done(17, 16 * (FRAME_CYC + 10) + 100, "burst_done");
        check("burst_pops", 64'(pop_cnt), 64'd17);
        check("burst_empty", 64'(fifo_empty), 64'd1);
        check("burst_rd_error", 64'(rd_error_cnt), 64'd0);

        // en_i dropped during the second of three queued frames
        set_en(1'b0);
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        s0 = mon_started;
        set_en(1'b1);
        wait_started(s0 + 2, 300, "en_second_start");
        set_en(1'b0);
        wait_done(19, 200, "en_second_done");
        repeat (30) @(posedge clk);
        check("en_hold_done", 64'(mon_done), 64'd19);
        check("en_hold_queued", 64'(fifo_cnt), 64'd1);
        check("en_hold_not_empty", 64'(fifo_empty), 64'd0);
        check("en_hold_pops", 64'(pop_cnt), 64'd19);
        set_en(1'b1);
        wait_done(20, 200, "en_resume_done");
        check("en_resume_empty", 64'(fifo_empty), 64'd1);

        // Reset during DATA bit 3 of 0xC3 (that bit is 0 on the line)
        write_byte(8'hC3);
        s0 = mon_started;
        wait_started(s0 + 1, 100, "rst_frame_start");
        repeat (16) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_tx", 64'(tx), 64'd0);
        #1 rst = 1'b1;
        #1;
        check("rst_async_tx", 64'(tx), 64'd1);
        check("rst_async_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        s0 = mon_started;
        idle_window(60, bad);
        check("post_rst_quiet", 64'(bad), 64'd0);
        check("post_rst_no_start", 64'(mon_started), 64'(s0));
        check("post_rst_pops", 64'(pop_cnt), 64'd21);
        check("post_rst_aborted", 64'(mon_aborted), 64'd1);

        // 0x07: odd number of ones, parity bit 1 when the parity build is used
        write_byte(8'h07);
        wait_done(21, 200, "last_done");
        repeat (10) @(posedge clk);

        check("final_pops", 64'(pop_cnt), 64'd22);
        check("no_rd_error", 64'(rd_error_cnt), 64'd0);
        check("no_stray_done", 64'(stray_done), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion after 500us, expected end of stimulus");
        $fatal(1);
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drain stage that sits directly downstream of fifo_sync.
- Pops one word at a time through the FIFO read interface and serialises it as an asynchronous UART frame on tx_o: start bit, WIDTH data bits LSB first, one stop bit.
- Lets the TX path buffer bursts in fifo_sync while the line runs at a fixed bit rate.

Parameters:
WIDTH, 8, data bits per frame; must equal the fifo_sync WIDTH.
CLKS_PER_BIT, 16, clk_i cycles per serial bit; must be 2 or more.

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous reset, active-high
en_i  input  1  permits starting a new frame; sampled only in IDLE
fifo_empty_i  input  1  connects to fifo_sync empty_o
fifo_rdata_i  input  WIDTH  connects to fifo_sync r_data_o
fifo_rd_en_o  output  1  connects to fifo_sync rd_en_i; registered single-cycle pulse
tx_o  output  1  serial line, idles high; registered
busy_o  output  1  high in every state except IDLE
frame_done_o  output  1  single-cycle pulse in the last cycle of the stop bit

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx_o=1, fifo_rd_en_o=0, busy_o=0, frame_done_o=0, shift register=0, counters=0.
- Upstream contract: fifo_sync updates r_data_o on the clock edge where rd_en_i is sampled high. Data is valid the following cycle.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - Moves to FETCH when en_i=1 and fifo_empty_i=0.
  - Otherwise holds, with tx_o=1.
- FETCH:
  - Lasts exactly 1 cycle; fifo_rd_en_o=1 only in this cycle.
  - Always moves to LOAD.
- LOAD:
  - Lasts 1 cycle; fifo_rdata_i is captured into the shift register.
  - Moves to START.
- Line state during IDLE, FETCH and LOAD: tx_o=1.
- START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx_o = shift register bit 0; the register shifts right every CLKS_PER_BIT cycles.
  - The bit counter runs 0..WIDTH-1; after bit WIDTH-1 completes, moves to STOP.
- STOP:
  - tx_o=1 for CLKS_PER_BIT cycles.
  - frame_done_o=1 in the final cycle of the stop bit, then return to IDLE.
- Bit timer:
  - Counter 0..CLKS_PER_BIT-1, cleared on every state change; a bit ends when the count equals CLKS_PER_BIT-1.
  - Width is clog2(CLKS_PER_BIT).
- Latency: tx_o falls exactly 3 clk_i edges after the cycle in which IDLE sees en_i=1 and fifo_empty_i=0.
- Frame length: (WIDTH+2)*CLKS_PER_BIT cycles, from the start bit through the end of the stop bit.
- Back-to-back frames with a non-empty FIFO and en_i=1: the gap between the end of the stop bit and the next start bit is exactly 3 idle-high cycles (IDLE, FETCH, LOAD).
- At most one pop per frame; fifo_rd_en_o is never asserted while fifo_empty_i=1 is sampled in IDLE. The block therefore never causes an fifo_sync rd_error_o.
- en_i deasserted mid-frame: the current frame completes; no new fetch occurs.
- fifo_empty_i changing mid-frame: ignored until the next IDLE.
- rst_i asserted mid-frame: tx_o returns to 1 immediately and the frame is abandoned. Nothing is re-popped.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_o = even parity (XOR of the WIDTH data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (WIDTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; the frame is as described above.

Decomposition:
- Package fifo_uart_tx_pkg holds:
  - the state encoding localparams (IDLE=0, FETCH=1, LOAD=2, START=3, DATA=4, PARITY=5, STOP=6);
  - a clog2 constant function used for the bit-timer and bit-counter widths.
- One sub-module, uart_bit_timer:
  - parameter CLKS_PER_BIT; inputs clk_i, rst_i, clr_i; output bit_end_o.
  - The FSM, shift register and bit counter stay in fifo_uart_tx.

Test Plan (CLKS_PER_BIT=4, WIDTH=8, fifo_sync DEPTH=16 as the upstream model):
- Reset: rst_i=1 for 20ns, no writes -> tx_o=1, busy_o=0, fifo_rd_en_o=0 throughout; no pulses while the FIFO is empty and en_i=1.
- Single byte 0xA5:
  - exactly one fifo_rd_en_o pulse; tx_o falls 3 edges after fifo_empty_i drops;
  - 4-cycle samples read 0,1,0,1,0,0,1,0,1,1; frame_done_o pulses once after 40 cycles.
- Burst of 16 $random bytes (FIFO full): 16 frames, byte order preserved, 3-cycle gaps, fifo_empty_i=1 after the 16th pop, and fifo_sync rd_error_o never asserts.
- en_i=0 during the 2nd frame of 3 queued bytes: the 2nd frame completes, the 3rd byte stays queued, and the FIFO is not empty. Re-asserting en_i sends the 3rd byte.
- rst_i pulsed during DATA bit 3: tx_o=1 and busy_o=0 immediately; after release with an empty FIFO, no further activity.
- With FIFO_UART_TX_PARITY_EN: byte 0x07 -> parity bit 1 before stop; frame_done_o after 44 cycles.
